// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, fetch queue entry type and PC helpers for the
//               LEGv8 CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    // Byte distance between consecutive instructions.
    localparam logic [PC_W-1:0] INSTR_BYTES = 64'd4;

    // One buffered instruction together with the byte address it came from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Address of the instruction issued n slots before the given pc.
    function automatic logic [PC_W-1:0] pc_rewind(input logic [PC_W-1:0] pc,
                                                  input logic [PC_W-1:0] n);
        return pc - (n << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small in-order queue of fetched {pc, instr} entries with a
//               registered head, synchronous clear and simultaneous push/pop.
//               A push while full is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // Qualify push/pop against occupancy; a clear wins over both.
    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_do_push = push && !w_full && !clear;
        w_do_pop  = pop && (r_count != '0) && !clear;
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : LEGv8 instruction-fetch stage. Owns the PC, issues sequential
//               instruction-memory requests under a credit limit of DEPTH,
//               queues returned words in order and hands them to decode over
//               valid/ready. A redirect reloads the PC, flushes the queue and
//               discards every response still owed by memory.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned
//               redirect target raises a sticky fetch_fault and halts fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               fetch_fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop;
    logic             r_fault;

    logic [CNT_W-1:0] w_count;
    logic             w_fifo_valid;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic             w_pop;
    logic [SUM_W-1:0] w_inflight;
    logic             w_req;
    logic             w_grant;
    logic             w_accept;
    logic [CNT_W-1:0] w_out_next;
    logic             w_misaligned;
    logic [PC_W-1:0]  w_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_target     = redirect_pc;
`else
    assign w_misaligned = 1'b0;
    assign w_target     = redirect_pc & ~PC_W'(3);
`endif

    // Issue credit, response accounting and tag reconstruction.
    always_comb begin
        w_pop      = w_fifo_valid && if_ready;
        // A head leaving this cycle frees its slot, which is what lets a
        // one-cycle memory sustain one instruction per cycle at DEPTH=2.
        w_inflight = SUM_W'(r_outstanding) + SUM_W'(w_count) - SUM_W'(w_pop);
        w_req      = !reset && !r_fault && (w_inflight < SUM_W'(DEPTH));
        w_grant    = w_req && imem_gnt;
        w_out_next = r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid);
        // Responses during a redirect belong to the old stream.
        w_accept   = imem_rvalid && !redirect_valid && (r_drop == '0);
        // With nothing left to drop, every outstanding request is from the
        // current stream, so the oldest one sits 'outstanding' slots behind pc.
        w_push_entry.pc    = pc_rewind(r_pc, PC_W'(r_outstanding));
        w_push_entry.instr = imem_rdata;
    end

    // PC, in-flight/drop counters and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything memory still owes us is stale, including a
                // request granted in this very cycle.
                r_drop <= w_out_next;
                if (w_misaligned) begin
                    r_fault <= 1'b1;
                end else begin
                    r_pc <= w_target;
                end
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + INSTR_BYTES;
                end
                if (imem_rvalid && (r_drop != '0)) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (w_accept),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .valid     (w_fifo_valid),
        .count     (w_count)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_valid    = w_fifo_valid;
    assign if_instr    = w_head.instr;
    assign if_pc       = w_head.pc;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a simple
//               in-order instruction memory of configurable latency whose
//               data word is the request address shifted right by two.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt       = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_ready       = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = 64'h0;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    logic [2:0]  m_vld;
    logic [63:0] m_addr [0:2];

    fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory: a granted request returns 'lat' cycles later, in order.
    always @(posedge clk) begin
        if (reset) begin
            m_vld <= 3'b000;
        end else begin
            m_vld     <= {m_vld[1:0], imem_req & imem_gnt};
            m_addr[0] <= imem_addr;
            m_addr[1] <= m_addr[0];
            m_addr[2] <= m_addr[1];
        end
    end

    assign imem_rvalid = m_vld[lat-1];
    assign imem_rdata  = m_addr[lat-1][33:2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int mem_lat, input logic ready);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        if_ready       = ready;
        lat            = mem_lat;
        repeat (2) step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lat   = 1;
        step();
        step();
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", if_valid); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0b exp=0", fetch_fault); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", imem_req); end
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL first_addr got=%0h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        apply_reset(1, 1'b1);
        for (int i = 0; i < 20 && !if_valid; i++) step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, if_valid); end
            checks++; if (if_pc !== 64'(4 * k)) begin failures++; $display("FAIL stream_pc got=%0h exp=%0h", if_pc, 4 * k); end
            checks++; if (if_instr !== 32'(k)) begin failures++; $display("FAIL stream_instr got=%0h exp=%0h", if_instr, k); end
            step();
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1, 1'b0);
        repeat (5) step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req got=%0b exp=0", imem_req); end
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", if_valid); end
        checks++; if (if_pc !== 64'h0) begin failures++; $display("FAIL bp_head got=%0h exp=0", if_pc); end
        if_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL bp_resume_valid k=%0d got=%0b exp=1", k, if_valid); end
            checks++; if (if_pc !== 64'(4 * k)) begin failures++; $display("FAIL bp_resume_pc got=%0h exp=%0h", if_pc, 4 * k); end
            checks++; if (if_instr !== 32'(k)) begin failures++; $display("FAIL bp_resume_instr got=%0h exp=%0h", if_instr, k); end
            step();
        end
    endtask

    task automatic test_redirect_stale();
        apply_reset(3, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stale_credit_req got=%0b exp=0", imem_req); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stale_flush got=%0b exp=0", if_valid); end
        checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL stale_addr got=%0h exp=100", imem_addr); end
        for (int i = 0; i < 30 && !if_valid; i++) step();
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stale_timeout got=%0b exp=1", if_valid); end
        checks++; if (if_pc !== 64'h100) begin failures++; $display("FAIL stale_pc got=%0h exp=100", if_pc); end
        checks++; if (if_instr !== 32'h40) begin failures++; $display("FAIL stale_instr got=%0h exp=40", if_instr); end
        step();
        for (int i = 0; i < 30 && !if_valid; i++) step();
        checks++; if (if_pc !== 64'h104) begin failures++; $display("FAIL stale_pc2 got=%0h exp=104", if_pc); end
        checks++; if (if_instr !== 32'h41) begin failures++; $display("FAIL stale_instr2 got=%0h exp=41", if_instr); end
    endtask

    task automatic test_redirect_collision();
        apply_reset(1, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL coll_req got=%0b exp=1", imem_req); end
        checks++; if (if_pc !== 64'h0) begin failures++; $display("FAIL coll_head got=%0h exp=0", if_pc); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL coll_flush got=%0b exp=0", if_valid); end
        checks++; if (imem_addr !== 64'h200) begin failures++; $display("FAIL coll_addr got=%0h exp=200", imem_addr); end
        for (int i = 0; i < 20 && !if_valid; i++) step();
        checks++; if (if_pc !== 64'h200) begin failures++; $display("FAIL coll_pc got=%0h exp=200", if_pc); end
        checks++; if (if_instr !== 32'h80) begin failures++; $display("FAIL coll_instr got=%0h exp=80", if_instr); end
        step();
        checks++; if (if_pc !== 64'h204) begin failures++; $display("FAIL coll_pc2 got=%0h exp=204", if_pc); end
        checks++; if (if_instr !== 32'h81) begin failures++; $display("FAIL coll_instr2 got=%0h exp=81", if_instr); end
    endtask

    task automatic test_align();
        apply_reset(1, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        step();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL align_fault got=%0b exp=1", fetch_fault); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL align_req got=%0b exp=0", imem_req); end
        repeat (5) step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL align_req_hold got=%0b exp=0", imem_req); end
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL align_sticky got=%0b exp=1", fetch_fault); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL align_flush got=%0b exp=0", if_valid); end
        apply_reset(1, 1'b1);
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL align_clear got=%0b exp=0", fetch_fault); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL align_restart got=%0b exp=1", imem_req); end
`else
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL align_fault got=%0b exp=0", fetch_fault); end
        checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL align_addr got=%0h exp=100", imem_addr); end
        for (int i = 0; i < 20 && !if_valid; i++) step();
        checks++; if (if_pc !== 64'h100) begin failures++; $display("FAIL align_pc got=%0h exp=100", if_pc); end
        checks++; if (if_instr !== 32'h40) begin failures++; $display("FAIL align_instr got=%0h exp=40", if_instr); end
`endif
    endtask

    task automatic test_reset_midstream();
        apply_reset(1, 1'b1);
        repeat (6) step();
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL mid_running got=%0b exp=1", if_valid); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%0b exp=0", imem_req); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", if_valid); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL mid_fault got=%0b exp=0", fetch_fault); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_restart_req got=%0b exp=1", imem_req); end
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL mid_restart_addr got=%0h exp=0", imem_addr); end
        for (int i = 0; i < 20 && !if_valid; i++) step();
        checks++; if (if_pc !== 64'h0) begin failures++; $display("FAIL mid_pc got=%0h exp=0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL mid_instr got=%0h exp=0", if_instr); end
        step();
        checks++; if (if_pc !== 64'h4) begin failures++; $display("FAIL mid_pc2 got=%0h exp=4", if_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collision();
        test_align();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
